// File: rtl/stage_ex_mem_if.sv
// ID/EX-to-EX/MEM bundle: pipeline inputs, hazard controls, redirect and registered outputs.
interface stage_ex_mem_if;
  logic        stall;
  logic        flush;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [3:0]  in_control;
  logic        in_reg_write;
  logic        in_wed;
  logic        in_is_branch_instr;
  logic        in_is_jmp_instr;
  logic        in_is_jmpr_instr;
  logic        in_ALUSrc;
  logic [1:0]  in_Result_Src;
  logic [31:0] in_dmem_temp_rslt;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_immediate;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic [31:0] fwd_mem_result;
  logic [31:0] fwd_wb_result;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] o_alu_result;
  logic [31:0] o_store_data;
  logic [31:0] o_dmem_temp_rslt;
  logic [31:0] o_pc_plus_4;
  logic [31:0] o_immediate;
  logic        o_reg_write;
  logic        o_wed;
  logic        o_misaligned;
  logic [1:0]  o_Result_Src;
  logic [4:0]  o_rd;
  logic [2:0]  o_func3;

  modport master (
    output stall, flush, in_A, in_B, in_control, in_reg_write, in_wed, in_is_branch_instr,
           in_is_jmp_instr, in_is_jmpr_instr, in_ALUSrc, in_Result_Src, in_dmem_temp_rslt,
           in_pc, in_pc_plus_4, in_immediate, in_rd, in_func3, fwd_sel_a, fwd_sel_b,
           fwd_mem_result, fwd_wb_result,
    input  pc_redirect, pc_target, o_alu_result, o_store_data, o_dmem_temp_rslt, o_pc_plus_4,
           o_immediate, o_reg_write, o_wed, o_misaligned, o_Result_Src, o_rd, o_func3
  );

  modport slave (
    input  stall, flush, in_A, in_B, in_control, in_reg_write, in_wed, in_is_branch_instr,
           in_is_jmp_instr, in_is_jmpr_instr, in_ALUSrc, in_Result_Src, in_dmem_temp_rslt,
           in_pc, in_pc_plus_4, in_immediate, in_rd, in_func3, fwd_sel_a, fwd_sel_b,
           fwd_mem_result, fwd_wb_result,
    output pc_redirect, pc_target, o_alu_result, o_store_data, o_dmem_temp_rslt, o_pc_plus_4,
           o_immediate, o_reg_write, o_wed, o_misaligned, o_Result_Src, o_rd, o_func3
  );
endinterface

// File: rtl/stage_ex_mem.sv
// Execute stage: operand forwarding, ALU, branch resolution with combinational redirect,
// and the EX/MEM pipeline register.
module stage_ex_mem (
  input logic           clk,
  input logic           rst,
  stage_ex_mem_if.slave bus
);
  logic [31:0] w_op_a, w_fwd_b, w_alu_b, w_alu_result, w_pc_target;
  logic        w_cmp, w_taken, w_misaligned;

  logic [31:0] r_alu_result, r_store_data, r_dmem_temp_rslt, r_pc_plus_4, r_immediate;
  logic        r_reg_write, r_wed, r_misaligned;
  logic [1:0]  r_Result_Src;
  logic [4:0]  r_rd;
  logic [2:0]  r_func3;

  always_comb begin
    case (bus.fwd_sel_a)
      2'b01:   w_op_a = bus.fwd_mem_result;
      2'b10:   w_op_a = bus.fwd_wb_result;
      default: w_op_a = bus.in_A;
    endcase
    case (bus.fwd_sel_b)
      2'b01:   w_fwd_b = bus.fwd_mem_result;
      2'b10:   w_fwd_b = bus.fwd_wb_result;
      default: w_fwd_b = bus.in_B;
    endcase
    w_alu_b = bus.in_ALUSrc ? bus.in_immediate : w_fwd_b;
  end

  always_comb begin
    w_alu_result = '0;
    case (bus.in_control)
      4'b0000: w_alu_result = w_op_a + w_alu_b;
      4'b0001: w_alu_result = w_op_a - w_alu_b;
      4'b0010: w_alu_result = w_op_a & w_alu_b;
      4'b0011: w_alu_result = w_op_a | w_alu_b;
      4'b0100: w_alu_result = w_op_a ^ w_alu_b;
      4'b0101: w_alu_result = w_op_a << w_alu_b[4:0];
      4'b0110: w_alu_result = w_op_a >> w_alu_b[4:0];
      4'b0111: w_alu_result = 32'($signed(w_op_a) >>> w_alu_b[4:0]);
      4'b1000: w_alu_result = {31'b0, $signed(w_op_a) < $signed(w_alu_b)};
      4'b1001: w_alu_result = {31'b0, w_op_a < w_alu_b};
      4'b1010: w_alu_result = w_alu_b;
      default: w_alu_result = '0;
    endcase
  end

  // Branch compare always uses the register operands, never the immediate.
  always_comb begin
    w_cmp = 1'b0;
    case (bus.in_func3)
      3'b000:  w_cmp = (w_op_a == w_fwd_b);
      3'b001:  w_cmp = (w_op_a != w_fwd_b);
      3'b100:  w_cmp = ($signed(w_op_a) < $signed(w_fwd_b));
      3'b101:  w_cmp = ($signed(w_op_a) >= $signed(w_fwd_b));
      3'b110:  w_cmp = (w_op_a < w_fwd_b);
      3'b111:  w_cmp = (w_op_a >= w_fwd_b);
      default: w_cmp = 1'b0;
    endcase
    w_taken      = (bus.in_is_branch_instr & w_cmp) | bus.in_is_jmp_instr | bus.in_is_jmpr_instr;
    w_pc_target  = bus.in_is_jmpr_instr ? ((w_op_a + bus.in_immediate) & ~32'h1)
                                        : (bus.in_pc + bus.in_immediate);
    w_misaligned = w_taken & (w_pc_target[1:0] != 2'b00);
  end

  assign bus.pc_redirect = w_taken & ~bus.stall & ~rst;
  assign bus.pc_target   = w_pc_target;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_alu_result     <= '0;
      r_store_data     <= '0;
      r_dmem_temp_rslt <= '0;
      r_pc_plus_4      <= '0;
      r_immediate      <= '0;
      r_reg_write      <= 1'b0;
      r_wed            <= 1'b0;
      r_misaligned     <= 1'b0;
      r_Result_Src     <= '0;
      r_rd             <= '0;
      r_func3          <= '0;
    end else if (!bus.stall) begin
      r_alu_result     <= w_alu_result;
      r_store_data     <= w_fwd_b;
      r_dmem_temp_rslt <= bus.in_dmem_temp_rslt;
      r_pc_plus_4      <= bus.in_pc_plus_4;
      r_immediate      <= bus.in_immediate;
      // A misaligned target must not commit any architectural side effect.
      r_reg_write      <= bus.in_reg_write & ~w_misaligned;
      r_wed            <= bus.in_wed & ~w_misaligned;
      r_misaligned     <= w_misaligned;
      r_Result_Src     <= bus.in_Result_Src;
      r_rd             <= bus.in_rd;
      r_func3          <= bus.in_func3;
    end
  end

  assign bus.o_alu_result     = r_alu_result;
  assign bus.o_store_data     = r_store_data;
  assign bus.o_dmem_temp_rslt = r_dmem_temp_rslt;
  assign bus.o_pc_plus_4      = r_pc_plus_4;
  assign bus.o_immediate      = r_immediate;
  assign bus.o_reg_write      = r_reg_write;
  assign bus.o_wed            = r_wed;
  assign bus.o_misaligned     = r_misaligned;
  assign bus.o_Result_Src     = r_Result_Src;
  assign bus.o_rd             = r_rd;
  assign bus.o_func3          = r_func3;
endmodule

// File: tb/tb_stage_ex_mem.sv
// Directed-vector bench for stage_ex_mem with a behavioural reference model checked every cycle.
module tb_stage_ex_mem;
  logic clk;
  logic rst;
  stage_ex_mem_if bus ();

  stage_ex_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu, sd, dt, pc4, imm;
    logic        rw, wed, mis;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } regs_t;

  int    total = 0;
  int    bad = 0;
  bit    chk_en = 0;
  regs_t exp_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] base);
    if (sel == 2'd1) return bus.fwd_mem_result;
    if (sel == 2'd2) return bus.fwd_wb_result;
    return base;
  endfunction

  function automatic logic m_taken();
    logic [31:0] a, b;
    logic        c;
    a = pick(bus.fwd_sel_a, bus.in_A);
    b = pick(bus.fwd_sel_b, bus.in_B);
    case (bus.in_func3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = (int'(a) < int'(b));
      3'd5: c = !(int'(a) < int'(b));
      3'd6: c = (a < b);
      3'd7: c = !(a < b);
      default: c = 1'b0;
    endcase
    return bus.in_is_jmpr_instr || bus.in_is_jmp_instr || (bus.in_is_branch_instr && c);
  endfunction

  function automatic logic [31:0] m_target();
    if (bus.in_is_jmpr_instr) return {pick(bus.fwd_sel_a, bus.in_A) + bus.in_immediate} >> 1 << 1;
    return bus.in_pc + bus.in_immediate;
  endfunction

  function automatic regs_t m_next();
    regs_t       n;
    logic [31:0] a, b;
    int          sa;
    a  = pick(bus.fwd_sel_a, bus.in_A);
    b  = bus.in_ALUSrc ? bus.in_immediate : pick(bus.fwd_sel_b, bus.in_B);
    sa = int'(b % 32);
    case (int'(bus.in_control))
      0:  n.alu = a + b;
      1:  n.alu = a + (~b + 1);
      2:  n.alu = a & b;
      3:  n.alu = a | b;
      4:  n.alu = a ^ b;
      5:  n.alu = a * (32'd1 << sa);
      6:  n.alu = a / (32'd1 << sa);
      7:  n.alu = a[31] ? ~((~a) / (32'd1 << sa)) : a / (32'd1 << sa);
      8:  n.alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  n.alu = (a < b) ? 32'd1 : 32'd0;
      10: n.alu = b;
      default: n.alu = 32'd0;
    endcase
    n.sd  = pick(bus.fwd_sel_b, bus.in_B);
    n.dt  = bus.in_dmem_temp_rslt;
    n.pc4 = bus.in_pc_plus_4;
    n.imm = bus.in_immediate;
    n.mis = m_taken() && (m_target() % 4 != 0);
    n.rw  = bus.in_reg_write && !n.mis;
    n.wed = bus.in_wed && !n.mis;
    n.rs  = bus.in_Result_Src;
    n.rd  = bus.in_rd;
    n.f3  = bus.in_func3;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst || bus.flush) exp_q <= '0;
    else if (!bus.stall) exp_q <= m_next();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("redirect", {31'b0, bus.pc_redirect}, {31'b0, m_taken() && !bus.stall && !rst});
      if (m_taken()) chk("target", bus.pc_target, m_target());
      chk("alu", bus.o_alu_result, exp_q.alu);
      chk("store", bus.o_store_data, exp_q.sd);
      chk("dtemp", bus.o_dmem_temp_rslt, exp_q.dt);
      chk("pc4", bus.o_pc_plus_4, exp_q.pc4);
      chk("imm", bus.o_immediate, exp_q.imm);
      chk("flags", {29'b0, bus.o_reg_write, bus.o_wed, bus.o_misaligned},
          {29'b0, exp_q.rw, exp_q.wed, exp_q.mis});
      chk("rs_rd_f3", {22'b0, bus.o_Result_Src, bus.o_rd, bus.o_func3},
          {22'b0, exp_q.rs, exp_q.rd, exp_q.f3});
    end
  end

  task automatic clear();
    bus.stall = 0; bus.flush = 0; bus.in_A = 0; bus.in_B = 0; bus.in_control = 0;
    bus.in_reg_write = 0; bus.in_wed = 0; bus.in_is_branch_instr = 0; bus.in_is_jmp_instr = 0;
    bus.in_is_jmpr_instr = 0; bus.in_ALUSrc = 0; bus.in_Result_Src = 0;
    bus.in_dmem_temp_rslt = 0; bus.in_pc = 0; bus.in_pc_plus_4 = 0; bus.in_immediate = 0;
    bus.in_rd = 0; bus.in_func3 = 0; bus.fwd_sel_a = 0; bus.fwd_sel_b = 0;
    bus.fwd_mem_result = 0; bus.fwd_wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want);
    clear();
    bus.in_control = op; bus.in_A = a; bus.in_B = b; bus.in_reg_write = 1; bus.in_rd = 5'd7;
    step();
    chk("alu_lit", bus.o_alu_result, want);
  endtask

  initial begin
    clear();
    rst = 1;
    step();
    chk_en = 1;
    step();
    chk("rst_alu", bus.o_alu_result, 32'd0);
    chk("rst_rw", {31'b0, bus.o_reg_write}, 32'd0);
    rst = 0;

    // Plain ADD
    clear();
    bus.in_A = 5; bus.in_B = 7; bus.in_rd = 3; bus.in_reg_write = 1;
    step();
    chk("add_res", bus.o_alu_result, 32'd12);
    chk("add_rd", {27'b0, bus.o_rd}, 32'd3);
    chk("add_rw", {31'b0, bus.o_reg_write}, 32'd1);

    // Forwarded A plus immediate
    clear();
    bus.in_A = 1; bus.fwd_mem_result = 32'h100; bus.fwd_sel_a = 2'b01;
    bus.in_immediate = 4; bus.in_ALUSrc = 1;
    step();
    chk("fwd_add", bus.o_alu_result, 32'h104);

    // Signed vs unsigned branch
    clear();
    bus.in_func3 = 3'b100; bus.in_A = 32'hFFFF_FFFF; bus.in_B = 1; bus.in_is_branch_instr = 1;
    bus.in_pc = 32'h40; bus.in_immediate = 32'hFFFF_FFF0;
    #1;
    chk("blt_redir", {31'b0, bus.pc_redirect}, 32'd1);
    chk("blt_tgt", bus.pc_target, 32'h30);
    bus.in_func3 = 3'b110;
    #1;
    chk("bltu_redir", {31'b0, bus.pc_redirect}, 32'd0);
    step();

    // JALR to odd address
    clear();
    bus.in_A = 32'h1003; bus.in_is_jmpr_instr = 1; bus.in_Result_Src = 2'b10;
    bus.in_pc_plus_4 = 32'h24; bus.in_reg_write = 1; bus.in_wed = 1;
    #1;
    chk("jalr_tgt", bus.pc_target, 32'h1002);
    step();
    chk("jalr_mis", {31'b0, bus.o_misaligned}, 32'd1);
    chk("jalr_rw", {30'b0, bus.o_reg_write, bus.o_wed}, 32'd0);
    chk("jalr_pc4", bus.o_pc_plus_4, 32'h24);

    // ALU op sweep
    alu_vec(4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_vec(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    alu_vec(4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    alu_vec(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA);
    alu_vec(4'b0101, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    alu_vec(4'b0110, 32'h8000_0000, 32'd31, 32'd1);
    alu_vec(4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_vec(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec(4'b1010, 32'd9, 32'h1234_5678, 32'h1234_5678);
    alu_vec(4'b1100, 32'd9, 32'd9, 32'd0);

    // WB forward on B, store data path
    clear();
    bus.in_B = 32'h11; bus.fwd_wb_result = 32'hCAFE; bus.fwd_sel_b = 2'b10; bus.in_wed = 1;
    bus.in_A = 2; bus.in_func3 = 3'b010; bus.in_is_branch_instr = 1;
    step();
    chk("wb_store", bus.o_store_data, 32'hCAFE);
    chk("wb_add", bus.o_alu_result, 32'hCB00);

    // Stall holds, flush wins over stall, redirect deferred until stall drops
    clear();
    bus.in_A = 9; bus.in_B = 4; bus.in_control = 4'b0001; bus.in_reg_write = 1;
    step();
    chk("sub_res", bus.o_alu_result, 32'd5);
    clear();
    bus.stall = 1; bus.in_A = 100; bus.in_B = 1; bus.in_is_jmp_instr = 1;
    bus.in_pc = 32'h100; bus.in_immediate = 8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_redir", {31'b0, bus.pc_redirect}, 32'd0);
      step();
      chk("stall_hold", bus.o_alu_result, 32'd5);
    end
    bus.flush = 1;
    step();
    chk("flush_alu", bus.o_alu_result, 32'd0);
    chk("flush_rw", {31'b0, bus.o_reg_write}, 32'd0);
    bus.flush = 0; bus.stall = 0;
    #1;
    chk("unstall_redir", {31'b0, bus.pc_redirect}, 32'd1);
    chk("unstall_tgt", bus.pc_target, 32'h108);
    bus.flush = 1;
    #1;
    chk("flush_redir", {31'b0, bus.pc_redirect}, 32'd1);
    step();
    chk("flush_bubble", bus.o_alu_result, 32'd0);

    // Reset mid-operation with stall and a pending jump
    clear();
    bus.in_A = 20; bus.in_B = 22; bus.in_reg_write = 1; bus.in_rd = 9;
    step();
    chk("pre_rst", bus.o_alu_result, 32'd42);
    rst = 1; bus.stall = 1; bus.in_is_jmp_instr = 1;
    #1;
    chk("rst_redir", {31'b0, bus.pc_redirect}, 32'd0);
    step();
    chk("rst_clr_alu", bus.o_alu_result, 32'd0);
    chk("rst_clr_rd", {27'b0, bus.o_rd}, 32'd0);
    rst = 0;
    clear();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_ex_mem.md
STAGE_EX_MEM -- requirements
Module: stage_ex_mem

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM register, suppress redirect
- flush  in  1  load bubble into EX/MEM register
- in_A, in_B  in  32  rs1/rs2 values from ID/EX
- in_control  in  4  ALU op
- in_reg_write, in_wed, in_is_branch_instr, in_is_jmp_instr, in_is_jmpr_instr, in_ALUSrc  in  1  ID/EX control bits
- in_Result_Src  in  2  writeback select
- in_dmem_temp_rslt, in_pc, in_pc_plus_4, in_immediate  in  32  ID/EX data
- in_rd  in  5  destination register
- in_func3  in  3  branch/memory sub-op
- fwd_sel_a, fwd_sel_b  in  2  forwarding selects from hazard unit
- fwd_mem_result, fwd_wb_result  in  32  forwarded values from MEM and WB
- pc_redirect  out  1  combinational, taken branch or jump
- pc_target  out  32  combinational redirect address
- o_alu_result, o_store_data, o_dmem_temp_rslt, o_pc_plus_4, o_immediate  out  32  registered
- o_reg_write, o_wed, o_misaligned  out  1  registered
- o_Result_Src  out  2  registered
- o_rd  out  5  registered
- o_func3  out  3  registered
REQ-002 SHALL use one clock and a synchronous, active-high reset. Clock and reset ports are named clk and rst.

Function
REQ-003 Operand select SHALL be: fwd_sel 00 gives in_A/in_B, 01 gives fwd_mem_result, 10 gives fwd_wb_result, 11 gives in_A/in_B. The result is opA and fwdB.
REQ-004 The ALU B input SHALL be in_immediate when in_ALUSrc=1; otherwise it SHALL be fwdB.
REQ-005 in_control SHALL decode as follows, with all 32-bit results and wrap-around arithmetic:
- 0000 ADD, 0001 SUB
- 0010 AND, 0011 OR, 0100 XOR
- 0101 SLL, 0110 SRL, 0111 SRA, using shift amount B[4:0]
- 1000 SLT (signed), 1001 SLTU, each giving a 1/0 result
- 1010 PASS_B
- 1011-1111 give result 0
REQ-006 Branch compare of opA against fwdB SHALL use in_func3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Values 010 and 011 SHALL be never taken.
REQ-007 The taken condition SHALL be (in_is_branch_instr AND compare true) OR in_is_jmp_instr OR in_is_jmpr_instr.
REQ-008 pc_target SHALL be in_pc+in_immediate for branch and jal. For jalr (in_is_jmpr_instr) it SHALL be (opA+in_immediate) with bit0 cleared. If more than one jump/branch flag is set, jmpr SHALL have priority over jmp, and jmp over branch.
REQ-009 pc_redirect SHALL equal taken AND NOT stall AND NOT rst. It SHALL be combinational, with zero-cycle latency to the fetch stage.
REQ-010 The EX/MEM register SHALL follow this rule at each rising clk edge, with priority rst > flush > stall > load:
- rst or flush: all o_* outputs become 0
- else stall: all o_* outputs are held
- else: o_* outputs load the values below
REQ-011 The loaded values SHALL be:
- o_alu_result = ALU result
- o_store_data = fwdB
- o_misaligned = taken AND (pc_target[1:0] != 0)
- every other o_* output = its in_* counterpart
REQ-012 Latency from in_* to o_* SHALL be exactly 1 cycle when not stalled.
REQ-013 o_misaligned=1 SHALL NOT gate pc_redirect. It SHALL force o_reg_write=0 and o_wed=0 in the loaded value.
REQ-014 When flush and a taken instruction occur in the same cycle, pc_redirect SHALL still assert (if stall=0) and the register SHALL load the bubble.
REQ-015 A stall held for N cycles SHALL keep pc_redirect low for those N cycles. The redirect SHALL fire in the first cycle stall deasserts, if the held ID/EX content is still taken.

Reset
REQ-016 While rst=1 at a clock edge, every registered output SHALL be 0 on the following cycle, regardless of stall or flush.
REQ-017 Reset asserted mid-operation SHALL discard the in-flight EX/MEM contents within one cycle.
REQ-018 pc_redirect SHALL be 0 whenever rst=1.
REQ-019 The block SHALL hold no state other than the EX/MEM register.

Verification
REQ-020 ADD: in_A=5, in_B=7, control=0000, ALUSrc=0, fwd_sel=00, rd=3, reg_write=1 -> next cycle o_alu_result=12, o_rd=3, o_reg_write=1.
REQ-021 Forwarding: in_A=1, fwd_mem_result=0x100, fwd_sel_a=01, in_immediate=4, ALUSrc=1, ADD -> o_alu_result=0x104.
REQ-022 Branch: in_func3=100, in_A=0xFFFFFFFF, in_B=1, branch=1, in_pc=0x40, imm=0xFFFFFFF0 -> pc_redirect=1, pc_target=0x30. Same stimulus with func3=110 -> pc_redirect=0.
REQ-023 JALR: in_A=0x1003, imm=0, jmpr=1, Result_Src=10, pc_plus_4=0x24 -> pc_target=0x1002, o_misaligned=1, o_reg_write=0, o_pc_plus_4=0x24.
REQ-024 Stall/flush: load SUB 9-4 (o_alu_result=5), then stall=1 for 3 cycles with new inputs -> o_alu_result stays 5. Then flush=1 with stall=1 -> all o_* become 0.
REQ-025 Reset: with valid data registered, assert rst=1 together with stall=1 for one edge -> all o_* become 0 and pc_redirect=0 during reset.
